// File: rtl/alu_muldiv_sequencer.sv
// rtl/alu_muldiv_sequencer.sv - multi-cycle MUL/DIVU/REMU sequencer driving the shared ALU
module alu_muldiv_sequencer #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] ALU_ADD  = 4'd0,
  parameter logic [3:0] ALU_SUB  = 4'd1,
  parameter logic [3:0] ALU_SLTU = 4'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_ADD = 3'd1,
    DIV_CMP = 3'd2,
    DIV_SUB = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t           state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] dvs;
  logic             ge;
  logic             is_rem;

  logic [WIDTH-1:0] rem_shift;
  logic             carry;
  logic [WIDTH-1:0] q_sub;
  logic [WIDTH-1:0] r_sub;

  // Shifted partial remainder is WIDTH+1 bits wide; its top bit rides in carry.
  assign rem_shift = {r[WIDTH-2:0], q[WIDTH-1]};
  assign carry     = r[WIDTH-1];
  assign q_sub     = ge ? {q[WIDTH-1:1], 1'b1} : q;
  assign r_sub     = ge ? alu_out : r;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    case (state)
      MUL_ADD: begin
        alu_a = acc;
        alu_b = mplier[0] ? mcand : '0;
      end
      DIV_CMP: begin
        alu_a  = rem_shift;
        alu_b  = dvs;
        alu_op = ALU_SLTU;
      end
      DIV_SUB: begin
        alu_a  = r;
        alu_b  = dvs;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      q      <= '0;
      r      <= '0;
      dvs    <= '0;
      ge     <= 1'b0;
      is_rem <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (kill && state != IDLE) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !kill) begin
            mcand  <= rs1;
            mplier <= rs2;
            q      <= rs1;
            dvs    <= rs2;
            r      <= '0;
            acc    <= '0;
            cnt    <= '0;
            is_rem <= (op == 2'd2);
            case (op)
              2'd0: begin
                state <= MUL_ADD;
                busy  <= 1'b1;
              end
              2'd1, 2'd2: begin
                if (rs2 == '0) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  result <= (op == 2'd1) ? '1 : rs1;
                end else begin
                  state <= DIV_CMP;
                  busy  <= 1'b1;
                end
              end
              default: begin
                state  <= DONE;
                done   <= 1'b1;
                result <= '0;
              end
            endcase
          end
        end
        MUL_ADD: begin
          acc    <= alu_out;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= alu_out;
          end
        end
        DIV_CMP: begin
          r     <= rem_shift;
          q     <= q << 1;
          ge    <= carry | ~alu_out[0];
          state <= DIV_SUB;
        end
        DIV_SUB: begin
          // Subtract slot is spent even when ge=0 so divide latency never varies.
          r   <= r_sub;
          q   <= q_sub;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= is_rem ? r_sub : q_sub;
          end else begin
            state <= DIV_CMP;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// tb/tb_alu_muldiv_sequencer.sv - bench for alu_muldiv_sequencer with an arithmetic reference model
module tb_alu_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1     (rs1),
    .rs2     (rs2),
    .kill    (kill),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_out (alu_out)
  );

  // Shared ALU: combinational, no internal registers.
  always_comb begin
    case (alu_op)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a - alu_b;
      4'd4:    alu_out = {31'd0, (alu_a < alu_b)};
      default: alu_out = 32'd0;
    endcase
  end

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] prod;
    prod = a * b;
    case (o)
      2'd0:    return prod;
      2'd1:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the sequencer idle; start is raised immediately.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int poke, input string tag);
    int lat_exp;
    int k;
    int busy_cnt;
    bit seen;
    lat_exp  = (o == 2'd0) ? 33 : ((o == 2'd3 || b == 32'd0) ? 1 : 65);
    op       = o;
    rs1      = a;
    rs2      = b;
    start    = 1'b1;
    k        = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      start = (k == poke);
      if (k == poke) begin
        op  = 2'd1;
        rs1 = $urandom;
        rs2 = $urandom_range(1, 50);
      end
      if (busy) busy_cnt++;
      if (k == 1 && lat_exp > 1) begin
        if (o == 2'd0) begin
          check({tag, "_mul_alu_op"}, {28'd0, alu_op}, 32'd0);
          check({tag, "_mul_alu_a"}, alu_a, 32'd0);
          check({tag, "_mul_alu_b"}, alu_b, b[0] ? a : 32'd0);
        end else begin
          check({tag, "_cmp_alu_op"}, {28'd0, alu_op}, 32'd4);
          check({tag, "_cmp_alu_a"}, alu_a, {31'd0, a[31]});
          check({tag, "_cmp_alu_b"}, alu_b, b);
        end
      end
      if (k == 2 && lat_exp == 65)
        check({tag, "_sub_alu_op"}, {28'd0, alu_op}, 32'd1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_latency"}, k, lat_exp);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy_cycles"}, busy_cnt, lat_exp - 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_result_held"}, result, exp_res);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    int          done_cnt;

    rst   = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    op    = 2'd0;
    rs1   = 32'd0;
    rs2   = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'd0, 32'd7, 32'd6, 32'd42, 0, "mul_7x6");
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, "mul_ones");
    run_op(2'd1, 32'd100, 32'd7, 32'd14, 0, "divu_100_7");
    run_op(2'd2, 32'd100, 32'd7, 32'd2, 0, "remu_100_7");
    run_op(2'd1, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 0, "divu_carry");
    run_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 0, "remu_carry");
    run_op(2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "divu_by0");
    run_op(2'd2, 32'd5, 32'd0, 32'd5, 0, "remu_by0");
    run_op(2'd3, 32'd9, 32'd9, 32'd0, 0, "illegal");
    run_op(2'd0, 32'd7, 32'd6, 32'd42, 5, "mul_poke");

    // kill at iteration 10 of a 3*5 multiply: result must stay 42
    op = 2'd0; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_done", {31'd0, done}, 32'd0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("kill_no_done", done_cnt, 0);
    check("kill_result", result, 32'd42);

    // start together with kill in IDLE is not accepted
    op = 2'd1; rs1 = 32'd50; rs2 = 32'd3; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("startkill_busy", {31'd0, busy}, 32'd0);
    done_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("startkill_idle", done_cnt, 0);

    // reset at iteration 10 clears the held result
    op = 2'd0; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 300);
        default: b = $urandom;
      endcase
      run_op(o, a, b, model(o, a, b), 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
Multi-cycle M-extension sequencer for the shared 32-bit ALU. It implements MUL (low word), DIVU and REMU by issuing one ALU operation per cycle: ADD for shift-add multiply, and SLTU then SUB for restoring divide. It sits beside the execute stage. While busy it owns the ALU operand/opcode mux, and the pipeline stalls on busy.

Parameters:
WIDTH, 32, datapath width; must equal ALU width
ALU_ADD, 4'd0, ALU opcode for add
ALU_SUB, 4'd1, ALU opcode for subtract
ALU_SLTU, 4'd4, ALU opcode for unsigned less-than

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  request pulse; sampled only in IDLE
op  in  2  0=MUL, 1=DIVU, 2=REMU, 3=illegal
rs1  in  WIDTH  multiplicand / dividend
rs2  in  WIDTH  multiplier / divisor
kill  in  1  pipeline flush; aborts the operation in flight
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle result-valid pulse
result  out  WIDTH  result; valid with done and held until next accept
alu_a  out  WIDTH  ALU operand A
alu_b  out  WIDTH  ALU operand B
alu_op  out  4  ALU opcode
alu_out  in  WIDTH  ALU result, combinational, same cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; busy=0, done=0, result=0; all internal registers 0.
- Reset has priority over every other input, including mid-operation.
- States: IDLE, MUL_ADD, DIV_CMP, DIV_SUB, DONE.
- 5-bit iteration counter cnt. All registers update on the rising edge.
- IDLE: alu_a=0, alu_b=0, alu_op=ALU_ADD. start=1 with kill=0 accepts:
  - Loads mcand=rs1, mplier=rs2, q=rs1, dvs=rs2, r=0, cnt=0.
  - op=0 -> MUL_ADD. op=1/2 with rs2!=0 -> DIV_CMP.
  - rs2==0 -> DONE directly, result = all-ones (DIVU) or rs1 (REMU).
  - op=3 -> DONE directly, result=0.
- MUL_ADD: alu_a=acc, alu_b = mplier[0] ? mcand : 0, alu_op=ALU_ADD.
  - Updates: acc<=alu_out, mcand<=mcand<<1, mplier<=mplier>>1, cnt++.
  - After the cnt=31 cycle -> DONE with result=acc (low 32 bits; overflow discarded).
- DIV_CMP: form rs={r[30:0],q[31]} and carry c=r[31].
  - Drive alu_a=rs, alu_b=dvs, alu_op=ALU_SLTU.
  - Updates: r<=rs, q<=q<<1, ge<=c | ~alu_out[0].
  - Carry rule: c=1 means the shifted remainder is at least 2^32 > dvs, so it subtracts.
- DIV_SUB: alu_a=r, alu_b=dvs, alu_op=ALU_SUB.
  - If ge: r<=alu_out (mod-2^32 wrap is exact here) and q[0]<=1.
  - Always cnt++. This cycle is taken even when ge=0, so latency is fixed.
  - After the cnt=31 pass -> DONE with result = q (DIVU) or r (REMU).
- DONE: done=1 for exactly one cycle, busy=0, result registered.
  - Next state is IDLE. start is not accepted in DONE.
- Latency, counted from accept edge to done-high cycle:
  - MUL: done high in the 33rd cycle after accept.
  - DIVU/REMU: 65th cycle.
  - Divide-by-zero and illegal op: 1st cycle.
- Back-to-back: the earliest next accept is the cycle after done, with one IDLE cycle between.
- busy=1 in MUL_ADD, DIV_CMP and DIV_SUB only.
- start while not IDLE: ignored, with no queueing.
- kill:
  - Any state other than IDLE -> IDLE next cycle; no done; result keeps its previous value.
  - kill together with start in IDLE: the start is not accepted.
- ALU output is never registered inside the ALU. Only this block's state registers capture alu_out.

Test Plan:
- MUL rs1=7, rs2=6 -> done in the 33rd cycle after accept, result=42; 0xFFFFFFFF*0xFFFFFFFF -> result=0x00000001.
- DIVU 100/7 -> result=14 in the 65th cycle; REMU 100/7 -> result=2; busy high for exactly 64 cycles.
- Carry path: DIVU 0xFFFFFFFF/0x80000001 -> 1; REMU same operands -> 0x7FFFFFFE.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; both in the 1st cycle, busy never asserts. Illegal op=3 -> result 0.
- Mid-operation control:
  - start pulsed during a MUL busy window -> ignored; the original result (42) is unaffected.
  - kill at iteration 10 -> IDLE next cycle, no done, result unchanged.
  - rst at iteration 10 -> busy=0, done=0, result=0.
- ALU drive check: during MUL_ADD with mplier[0]=0, alu_b=0 and alu_op=0; in DIV_CMP alu_op=4, in DIV_SUB alu_op=1.
